// File: rtl/pixel_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_stream_packer                                          |
// | Description : Tags shaded pixels with raster SOF/EOL, buffers them in a    |
// |               FIFO and streams them out over ready/valid. Optional         |
// |               per-frame checksum output via PIXEL_STREAM_CHECKSUM_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_stream_packer #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int PIXEL_HEIGHT = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int COLOR_BITS   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3*COLOR_BITS-1:0] color_in,
    input  logic                    valid_in,
    output logic [3*COLOR_BITS-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_sof,
    output logic                    m_eol,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overflow,
`ifdef PIXEL_STREAM_CHECKSUM_EN
    output logic [23:0]             frame_sum,
`endif
    output logic [15:0]             dropped_count
);

    localparam int c_DW = 3 * COLOR_BITS;
    localparam int c_EW = c_DW + 2;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_XW = (PIXEL_WIDTH  > 1) ? $clog2(PIXEL_WIDTH)  : 1;
    localparam int c_YW = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1;

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(PIXEL_WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(PIXEL_HEIGHT - 1);
    localparam logic [c_CW-1:0] c_FULL   = c_CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic [c_EW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              r_overflow;
    logic [15:0]       r_dropped;

    logic              w_start;
    logic              w_pixel;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_sof;
    logic [c_EW-1:0]   w_head;

    assign w_start  = (r_state == S_IDLE) && start;
    assign w_pixel  = (r_state == S_STREAM) && valid_in;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign w_pop    = !w_empty && m_ready;
    // A full FIFO still takes a pixel when the head leaves in the same cycle.
    assign w_push   = w_pixel && (!w_full || w_pop);
    assign w_drop   = w_pixel && w_full && !w_pop;
    assign w_x_last = (r_x == c_X_LAST);
    assign w_y_last = (r_y == c_Y_LAST);
    assign w_sof    = (r_x == '0) && (r_y == '0);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_STREAM;
            S_STREAM: if (w_pixel && w_x_last && w_y_last) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_empty) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Raster position advances on every pixel, dropped or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_start) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pixel) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {color_in, w_sof, w_x_last};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (w_start) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 1'b1;
        end
    end

`ifdef PIXEL_STREAM_CHECKSUM_EN
    logic [23:0] r_frame_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_sum <= '0;
        end else if (w_start) begin
            r_frame_sum <= '0;
        end else if (w_pop) begin
            r_frame_sum <= r_frame_sum + 24'(m_data);
        end
    end

    assign frame_sum = r_frame_sum;
`endif

    // Head entry is gated so every stream output reads zero while empty or in reset.
    assign m_valid       = !w_empty;
    assign m_data        = w_empty ? '0 : w_head[c_EW-1:2];
    assign m_sof         = !w_empty && w_head[1];
    assign m_eol         = !w_empty && w_head[0];
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_DONE);
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_stream_packer                                       |
// | Description : Table-driven frames with a scoreboard of expected pixels,    |
// |               plus a mid-frame asynchronous reset sequence.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pixel_stream_packer;

    localparam int PW    = 8;
    localparam int PH    = 8;
    localparam int NPIX  = PW * PH;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] color_in = '0;
    logic        valid_in = 1'b0;
    logic        m_ready = 1'b1;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_sof;
    logic        m_eol;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [15:0] dropped_count;
`ifdef PIXEL_STREAM_CHECKSUM_EN
    logic [23:0] frame_sum;
`endif

    always #5 clk = ~clk;

    pixel_stream_packer #(
        .PIXEL_WIDTH (PW),
        .PIXEL_HEIGHT(PH),
        .FIFO_DEPTH  (DEPTH),
        .COLOR_BITS  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .color_in     (color_in),
        .valid_in     (valid_in),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sof        (m_sof),
        .m_eol        (m_eol),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow),
`ifdef PIXEL_STREAM_CHECKSUM_EN
        .frame_sum    (frame_sum),
`endif
        .dropped_count(dropped_count)
    );

    typedef struct {
        logic [23:0] base;
        logic        vary;
        int          stall;
        logic        exp_ovf;
        logic [15:0] exp_drop;
    } vec_t;

    typedef struct packed {
        logic [23:0] d;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        q[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        drv_accept = 1'b0;
    logic        drv_sof = 1'b0;
    logic        drv_eol = 1'b0;
    int          cyc = 0;
    int          done_pulses = 0;
    int          last_xfer_cyc = -100;
    logic [23:0] sum_model = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: entries pushed this cycle become visible on the next one.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (frame_done) done_pulses++;
        if (mon_en) begin
            chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
            if (m_valid && q.size() != 0) begin
                chk("m_data", 32'(m_data), 32'(q[0].d));
                chk("m_sof", 32'(m_sof), 32'(q[0].sof));
                chk("m_eol", 32'(m_eol), 32'(q[0].eol));
                if (m_ready) begin
                    sum_model = sum_model + q[0].d;
                    void'(q.pop_front());
                    last_xfer_cyc = cyc;
                end
            end
            if (frame_done) begin
                chk("done_latency", 32'(cyc - last_xfer_cyc), 32'd2);
`ifdef PIXEL_STREAM_CHECKSUM_EN
                chk("frame_sum_at_done", 32'(frame_sum), 32'(sum_model));
`endif
            end
            if (valid_in && drv_accept) begin
                e = '{d: color_in, sof: drv_sof, eol: drv_eol};
                q.push_back(e);
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int base_done;
        base_done = done_pulses;
        @(posedge clk); #1;
        start = 1'b1;
        sum_model = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            valid_in   = 1'b1;
            color_in   = v.vary ? v.base + 24'(i) : v.base;
            m_ready    = (i >= v.stall);
            drv_sof    = (i == 0);
            drv_eol    = ((i % PW) == PW - 1);
            drv_accept = (i >= v.stall) || (i < DEPTH);
            @(posedge clk); #1;
        end
        // Pixels offered during drain/done/idle must be ignored, not counted.
        color_in   = 24'hDEAD00;
        drv_accept = 1'b0;
        m_ready    = 1'b1;
        for (int k = 0; k < 200 && done_pulses == base_done; k++) @(negedge clk);
        chk("frame_done_seen", 32'(done_pulses - base_done), 32'd1);
        repeat (5) @(negedge clk);
        valid_in = 1'b0;
        chk("frame_done_once", 32'(done_pulses - base_done), 32'd1);
        chk("overflow", 32'(overflow), 32'(v.exp_ovf));
        chk("dropped_count", 32'(dropped_count), 32'(v.exp_drop));
        chk("busy_after", 32'(busy), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef PIXEL_STREAM_CHECKSUM_EN
        chk("frame_sum_held", 32'(frame_sum), 32'(sum_model));
        if (v.base == 24'h000001 && !v.vary) chk("frame_sum_ones", 32'(frame_sum), 32'h40);
`endif
    endtask

    initial begin
        int base_done;
        vecs[0] = '{base: 24'hFF0000, vary: 1'b0, stall: 0,  exp_ovf: 1'b0, exp_drop: 16'd0};
        vecs[1] = '{base: 24'h00FF00, vary: 1'b0, stall: 12, exp_ovf: 1'b0, exp_drop: 16'd0};
        vecs[2] = '{base: 24'h0000A0, vary: 1'b1, stall: 20, exp_ovf: 1'b1, exp_drop: 16'd4};
        vecs[3] = '{base: 24'h000001, vary: 1'b0, stall: 0,  exp_ovf: 1'b0, exp_drop: 16'd0};
        vecs[4] = '{base: 24'h123456, vary: 1'b1, stall: 30, exp_ovf: 1'b1, exp_drop: 16'd14};

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_dropped", 32'(dropped_count), 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int t = 0; t < 5; t++) run_frame(vecs[t]);

        // Mid-frame reset after pixel 30 with the FIFO stalled and overflowing.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            valid_in   = 1'b1;
            color_in   = 24'h0F0F00 + 24'(i);
            m_ready    = 1'b0;
            drv_sof    = (i == 0);
            drv_eol    = ((i % PW) == PW - 1);
            drv_accept = (i < DEPTH);
            @(posedge clk); #1;
        end
        valid_in   = 1'b0;
        drv_accept = 1'b0;
        @(negedge clk); #2;
        chk("pre_rst_m_valid", 32'(m_valid), 32'd1);
        chk("pre_rst_overflow", 32'(overflow), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_m_data", 32'(m_data), 32'd0);
        chk("async_m_sof", 32'(m_sof), 32'd0);
        chk("async_m_eol", 32'(m_eol), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_frame_done", 32'(frame_done), 32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        chk("async_dropped", 32'(dropped_count), 32'd0);
        q.delete();
        base_done = done_pulses;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        m_ready = 1'b1;
        mon_en  = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_reset", 32'(done_pulses - base_done), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);

        run_frame(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Sink stage directly downstream of the Lambertian shader.
- Takes one shaded pixel per `valid_in` pulse; the shader has no back-pressure.
- Tags each pixel with raster position: start-of-frame and end-of-line flags.
- Buffers pixels in an internal FIFO and streams them out over a ready/valid interface to the framebuffer/display writer.
- Detects overflow and signals frame completion.

Parameters:
- PIXEL_WIDTH, 8, pixels per line.
- PIXEL_HEIGHT, 8, lines per frame.
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
- COLOR_BITS, 8, bits per channel; pixel word is 3*COLOR_BITS, packed {r,g,b}, r in MSBs.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  arm one frame; sampled only in IDLE.
- color_in  in  3*COLOR_BITS  shaded pixel {r,g,b}.
- valid_in  in  1  color_in valid this cycle; no ready is returned.
- m_data  out  3*COLOR_BITS  output pixel.
- m_valid  out  1  m_data/m_sof/m_eol valid.
- m_ready  in  1  downstream accepts; a transfer occurs when m_valid && m_ready.
- m_sof  out  1  pixel (0,0) of frame.
- m_eol  out  1  pixel x == PIXEL_WIDTH-1.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- overflow  out  1  sticky: at least one pixel dropped this frame.
- dropped_count  out  16  pixels dropped this frame; saturates at 16'hFFFF.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset==0, any time, including mid-frame):
  - State goes to IDLE; FIFO pointers/count cleared.
  - x/y counters go to 0.
  - All outputs go to 0: m_data, m_valid, m_sof, m_eol, busy, frame_done, overflow, dropped_count.
  - A frame in flight is discarded; no frame_done is issued for it.
- States:
  - IDLE: ignores valid_in. start==1 -> STREAM; clears x, y, overflow, dropped_count. A frame is never auto-restarted.
  - STREAM: each valid_in cycle is one pixel at the current (x,y).
    - Entry written = {color_in, sof=(x==0&&y==0), eol=(x==PIXEL_WIDTH-1)}.
    - x increments; at PIXEL_WIDTH-1, x wraps to 0 and y increments.
    - The pixel with x==PIXEL_WIDTH-1 && y==PIXEL_HEIGHT-1 is the last one and causes STREAM -> DRAIN.
    - The counter advances even if the pixel is dropped, so geometry never slips.
  - DRAIN: valid_in is ignored and not counted as dropped. When the FIFO is empty and no transfer is pending -> DONE.
  - DONE: frame_done=1 for exactly this cycle -> IDLE. start in the same cycle is ignored.
- FIFO:
  - Registered count 0..FIFO_DEPTH; full = (count==FIFO_DEPTH).
  - Push when full: accepted only if a pop occurs in the same cycle (count unchanged). Otherwise the pixel is dropped, overflow<=1 and dropped_count increments (saturating).
  - Simultaneous push and pop when empty: no bypass. The pushed word appears on m_data the next cycle.
  - Latency: a push into an empty FIFO at edge N gives m_valid=1 with that data after edge N. One cycle, registered output.
  - m_data/m_sof/m_eol are held stable while m_valid && !m_ready. m_valid never drops without a transfer.
  - Pointers wrap modulo FIFO_DEPTH.
- busy: 1 in STREAM, DRAIN and DONE.

Optional Feature:
- Macro: PIXEL_STREAM_CHECKSUM_EN.
- Defined:
  - Adds output frame_sum (out, 24 bits): modulo-2^24 sum of {r,g,b} of every transferred pixel (on m_valid && m_ready) in the frame.
  - Cleared on start acceptance and on reset.
  - Stable and valid in the frame_done cycle; held until the next start.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame: reset low 2 cycles, start, then 64 valid_in pulses of 24'hFF0000 with m_ready=1.
  - Expect 64 transfers; m_sof only on the first; m_eol on transfers 8,16,…,64.
  - frame_done once, 1 cycle after the last transfer drains; overflow=0.
- Back-pressure: same 64 pixels, 24'h00FF00, with m_ready=0 for the first 12 cycles after start, then 1.
  - Expect no drops (peak count 12 ≤ 16), data order preserved, m_data held while stalled.
- Overflow: m_ready=0 throughout 20 valid_in pulses, then m_ready=1.
  - Expect overflow=1, dropped_count=4, the first 16 pixels delivered intact.
  - Expect m_sof on the first delivered pixel and frame_done after the remaining 44 pixels arrive.
- Full push+pop: FIFO full with m_ready=1 and valid_in=1 on the same cycle.
  - Expect count stays 16, no drop, dropped_count unchanged.
- Mid-frame reset: pulse reset low after pixel 30.
  - Expect all outputs 0 immediately (asynchronous), no frame_done.
  - A new start + 64 pixels yields a clean frame with m_sof on its first pixel.
- Checksum (PIXEL_STREAM_CHECKSUM_EN): 64 pixels of 24'h000001.
  - Expect frame_sum=24'h000040 at frame_done.
